// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for four requesters sharing one 2-to-4 active-low-enable
// decoder. Registers a one-hot grant and its encoded index {w1,w0}, and drives
// the decoder enable.
// Every handover passes through one dead cycle, so the decoder never switches
// directly between two live outputs.
//
// Optional feature: define the macro ARB_TIMEOUT_EN to build the hold-timeout
// logic. With it, a grant that has lasted MAX_HOLD cycles while another
// requester waits is revoked, and preempt pulses for one cycle. Without it,
// no counter is built and preempt is tied low.
module rr_decoder_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       dec_en_n,
  output logic       preempt
);

  // Reject parameter sets the hold counter cannot represent.
  if (MAX_HOLD < 2 || (2 ** CNT_W) <= MAX_HOLD) begin : g_param_check
    $error("rr_decoder_arbiter: need MAX_HOLD >= 2 and 2**CNT_W > MAX_HOLD");
  end

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] ptr_q, ptr_d;
  logic       preempt_d;

  logic       pick_valid;
  logic [1:0] pick_idx;
  logic [1:0] cand;
  logic       timeout_hit;

  // Round-robin pick: first set request at ptr, ptr+1, ... (mod 4).
  // The scan runs from the farthest offset down, so the nearest hit wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             preempt_q;

  // Revoke only when the owner is at its limit and somebody else is waiting.
  assign timeout_hit = (hold_cnt_q == HoldLast) && ((req & ~gnt_q) != 4'b0000);

  // Hold counter: cleared on entry to GRANT, counts GRANT cycles, saturates.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q != StGrant && state_d == StGrant) begin
      hold_cnt_d = '0;
    end else if (state_q == StGrant && hold_cnt_q != HoldLast) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end
  end

  // Hold counter and preempt pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
      preempt_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      preempt_q  <= preempt_d;
    end
  end

  assign preempt = preempt_q;
`else
  assign timeout_hit = 1'b0;
  assign preempt     = 1'b0;

  // Keeps the pulse request visibly consumed in the timeout-free build.
  logic unused_preempt;
  assign unused_preempt = preempt_d;
`endif

  // Next-state logic for the IDLE / GRANT / GAP controller.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    preempt_d = 1'b0;
    unique case (state_q)
      StGrant: begin
        if (!req[idx_q]) begin
          // Owner released: rotate priority past it.
          state_d = StGap;
          gnt_d   = 4'b0000;
          ptr_d   = idx_q + 2'd1;
        end else if (timeout_hit) begin
          // Forced rotation: owner drops to lowest priority.
          state_d   = StGap;
          gnt_d     = 4'b0000;
          ptr_d     = idx_q + 2'd1;
          preempt_d = 1'b1;
        end
      end
      default: begin
        // IDLE and GAP both arbitrate; GAP lasts exactly one cycle.
        if (!en_n && pick_valid) begin
          state_d = StGrant;
          gnt_d   = 4'b0001 << pick_idx;
          idx_d   = pick_idx;
        end else begin
          state_d = StIdle;
          gnt_d   = 4'b0000;
        end
      end
    endcase
  end

  // Controller state, grant, index and rotation pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= 4'b0000;
      idx_q   <= 2'd0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt_q;
  assign dec_en_n  = ~gnt_valid;

  // Structural invariants of the grant encoding.
  a_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_idx_match : assert property (@(posedge clk) disable iff (rst)
                                 (gnt_q != 4'b0000) |-> (gnt_q == (4'b0001 << idx_q)));

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
module tb_rr_decoder_arbiter;

  logic       clk;
  logic       rst;
  logic       en_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       dec_en_n;
  logic       preempt;

  int vectors;
  int miscompares;

  rr_decoder_arbiter #(
    .MAX_HOLD(8),
    .CNT_W   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en_n     (en_n),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .dec_en_n (dec_en_n),
    .preempt  (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Return to the reset state (ptr = 0) with no requests pending.
  task automatic do_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    en_n = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 4'b1111;
    en_n = 1'b0;
    tick();
    tick();
    vectors++;
    if (gnt !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_gnt: got %b want 0000", gnt);
    end
    vectors++;
    if (gnt_valid !== 1'b0 || dec_en_n !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_valid: got valid=%b dec_en_n=%b want 0/1", gnt_valid, dec_en_n);
    end
    vectors++;
    if (preempt !== 1'b0 || gnt_idx !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_misc: got preempt=%b idx=%0d want 0/0", preempt, gnt_idx);
    end
    req = 4'b0000;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    tick();
    vectors++;
    if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || dec_en_n !== 1'b0 || gnt_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL single_grant: got gnt=%b idx=%0d dec_en_n=%b valid=%b want 0100/2/0/1",
               gnt, gnt_idx, dec_en_n, gnt_valid);
    end
    req = 4'b0000;
    tick();
    vectors++;
    if (gnt !== 4'b0000 || dec_en_n !== 1'b1) begin
      miscompares++;
      $display("FAIL single_release: got gnt=%b dec_en_n=%b want 0000/1", gnt, dec_en_n);
    end
    vectors++;
    if (gnt_idx !== 2'd2) begin
      miscompares++;
      $display("FAIL single_idx_hold: got idx=%0d want 2", gnt_idx);
    end
    tick();
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (gnt !== exp_g[k]) begin
        miscompares++;
        $display("FAIL rotation_grant%0d: got %b want %b", k, gnt, exp_g[k]);
      end
      if (k == 4) break;
      tick();
      req = 4'b1111 & ~exp_g[k];
      tick();
      vectors++;
      if (gnt !== 4'b0000) begin
        miscompares++;
        $display("FAIL rotation_gap%0d: got %b want 0000", k, gnt);
      end
      req = 4'b1111;
      tick();
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    tick();
    req = 4'b1000;
    tick();
    vectors++;
    if (gnt !== 4'b1000) begin
      miscompares++;
      $display("FAIL wrap_owner3: got %b want 1000", gnt);
    end
    req = 4'b0000;
    tick();
    req = 4'b1001;
    tick();
    vectors++;
    if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
      miscompares++;
      $display("FAIL wrap_ptr: got gnt=%b idx=%0d want 0001/0", gnt, gnt_idx);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_enable();
    do_reset();
    en_n = 1'b1;
    req  = 4'b0010;
    tick();
    tick();
    vectors++;
    if (gnt !== 4'b0000) begin
      miscompares++;
      $display("FAIL enable_block: got %b want 0000", gnt);
    end
    en_n = 1'b0;
    tick();
    vectors++;
    if (gnt !== 4'b0010) begin
      miscompares++;
      $display("FAIL enable_grant: got %b want 0010", gnt);
    end
    en_n = 1'b1;
    tick();
    tick();
    vectors++;
    if (gnt !== 4'b0010) begin
      miscompares++;
      $display("FAIL enable_hold: got %b want 0010", gnt);
    end
    req = 4'b0000;
    tick();
    req = 4'b0010;
    tick();
    tick();
    vectors++;
    if (gnt !== 4'b0000 || dec_en_n !== 1'b1) begin
      miscompares++;
      $display("FAIL enable_no_regrant: got gnt=%b dec_en_n=%b want 0000/1", gnt, dec_en_n);
    end
    en_n = 1'b0;
    req  = 4'b0000;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0011;
    tick();
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (gnt !== 4'b0001) begin
        miscompares++;
        $display("FAIL b2b_hold%0d: got %b want 0001", c, gnt);
      end
      tick();
    end
    req = 4'b0010;
    tick();
    vectors++;
    if (gnt !== 4'b0000 || preempt !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_gap: got gnt=%b preempt=%b want 0000/0", gnt, preempt);
    end
    tick();
    vectors++;
    if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
      miscompares++;
      $display("FAIL b2b_next: got gnt=%b idx=%0d want 0010/1", gnt, gnt_idx);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req = 4'b0001;
    tick();
    for (int c = 1; c <= 8; c++) begin
      vectors++;
      if (gnt !== 4'b0001 || preempt !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout_hold%0d: got gnt=%b preempt=%b want 0001/0", c, gnt, preempt);
      end
      if (c == 2) req = 4'b0011;
      tick();
    end
    vectors++;
    if (gnt !== 4'b0000 || preempt !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_revoke: got gnt=%b preempt=%b want 0000/1", gnt, preempt);
    end
    tick();
    vectors++;
    if (gnt !== 4'b0010 || preempt !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_next: got gnt=%b preempt=%b want 0010/0", gnt, preempt);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask
`else
  task automatic test_timeout();
    do_reset();
    req = 4'b0001;
    tick();
    for (int c = 1; c <= 12; c++) begin
      vectors++;
      if (gnt !== 4'b0001 || preempt !== 1'b0) begin
        miscompares++;
        $display("FAIL notimeout_hold%0d: got gnt=%b preempt=%b want 0001/0", c, gnt, preempt);
      end
      if (c == 2) req = 4'b0011;
      tick();
    end
    req = 4'b0000;
    tick();
    tick();
  endtask
`endif

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0100;
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (gnt !== 4'b0000 || dec_en_n !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_gnt: got gnt=%b dec_en_n=%b want 0000/1", gnt, dec_en_n);
    end
    rst = 1'b0;
    req = 4'b1111;
    tick();
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL midreset_ptr: got %b want 0001", gnt);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    en_n        = 1'b1;
    req         = 4'b0000;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_enable();
    test_back_to_back();
    test_timeout();
    test_reset_mid_grant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
